ifetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC-calculation stage.
//  - Takes the registered PC, issues one request at a time to instruction memory over a req/gnt + rvalid handshake.
//  - Buffers returned {pc, instr} pairs in a small FIFO and presents them to decode with valid/ready.
//  - Back-pressures the PC stage with pc_stall; drops wrong-path fetches on redirect.

---
 rtl/ifetch_unit.sv | 171 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, small {pc, instr} FIFO toward decode.
// Optional misaligned-PC fault path is enabled with `define FETCH_MISALIGN_CHK_EN.
module ifetch_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];

  logic              room, misalign, push, pop;
  logic [31:0]       push_instr;
  logic [ADDR_W-1:0] push_pc;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_mem_q [DEPTH];
  logic fault_mem_d [DEPTH];
  logic push_fault;
`endif

  assign imem_addr = {pc[ADDR_W-1:2], 2'b00};
  assign id_instr  = instr_mem_q[rd_ptr_q];
  assign id_pc     = pc_mem_q[rd_ptr_q];

`ifdef FETCH_MISALIGN_CHK_EN
  assign id_fault  = fault_mem_q[rd_ptr_q];
`else
  assign id_fault  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    imem_req   = 1'b0;
    pc_stall   = 1'b1;
    push       = 1'b0;
    push_instr = imem_rdata;
    push_pc    = pend_pc_q;
    room       = (count_q != FULL);
`ifdef FETCH_MISALIGN_CHK_EN
    misalign   = (pc[1:0] != 2'b00);
    push_fault = 1'b0;
`else
    misalign   = 1'b0;
`endif

    case (state_q)
      S_ISSUE: begin
        if (misalign) begin
          // A misaligned PC never reaches memory; a NOP carrying the fault goes to decode instead.
          if (room && !redirect) begin
            push       = 1'b1;
            push_instr = NOP;
            push_pc    = pc;
            pc_stall   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            push_fault = 1'b1;
`endif
          end
        end else begin
          imem_req = room && !redirect;
          if (imem_req && imem_gnt) begin
            pend_pc_d = pc;
            pc_stall  = 1'b0;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push    = !redirect;
          state_d = S_ISSUE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase

    if (rst) begin
      imem_req = 1'b0;
      pc_stall = 1'b1;
      push     = 1'b0;
    end

    id_valid = (count_q != '0) && !redirect && !rst;
    pop      = id_valid && id_ready;

    // Flush wins over any push or pop in the same cycle.
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_mem_d = fault_mem_q;
`endif
    if (push) begin
      instr_mem_d[wr_ptr_q] = push_instr;
      pc_mem_d[wr_ptr_q]    = push_pc;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_mem_d[wr_ptr_q] = push_fault;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ISSUE;
      pend_pc_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_mem_q <= fault_mem_d;
`endif
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: table-driven cycle vectors plus hand-built redirect/reset sequences.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  int tests_run;
  int fail_count;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        redirect;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  ifetch_unit #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .redirect(redirect),
    .pc_stall(pc_stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_fault(id_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(
    input logic r, input logic [31:0] p, input logic rd, input logic g, input logic rv,
    input logic [31:0] dat, input logic rdy, input logic es, input logic erq,
    input logic [31:0] ea, input logic ev, input logic [31:0] ei, input logic [31:0] ep,
    input logic ef);
    vec_t v;
    v.rst = r; v.pc = p; v.redirect = rd; v.gnt = g; v.rvalid = rv; v.rdata = dat; v.ready = rdy;
    v.e_stall = es; v.e_req = erq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    v.e_fault = ef;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    pc          = v.pc;
    redirect    = v.redirect;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rvalid;
    imem_rdata  = v.rdata;
    id_ready    = v.ready;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    cmp({tag, ".pc_stall"}, {31'b0, pc_stall}, {31'b0, v.e_stall});
    cmp({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, v.e_req});
    cmp({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, v.e_valid});
    if (v.e_req) cmp({tag, ".imem_addr"}, imem_addr, v.e_addr);
    if (v.e_valid) begin
      cmp({tag, ".id_instr"}, id_instr, v.e_instr);
      cmp({tag, ".id_pc"}, id_pc, v.e_pc);
      cmp({tag, ".id_fault"}, {31'b0, id_fault}, {31'b0, v.e_fault});
    end
  endtask

  // Drive at the falling edge, check combinational outputs 1 ns later, well before the rising edge.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(tag, v);
  endtask

  vec_t tbl[$];

  initial begin
    tests_run   = 0;
    fail_count  = 0;
    rst         = 1'b1;
    pc          = '0;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    id_ready    = 1'b0;

    // Streaming fetch with decode always ready: one instruction every two cycles.
    //           rst pc        rd g  rv rdata          rdy stl req addr       vld instr          pc     flt
    tbl.push_back(mkv(1, 32'h0,  0, 1, 0, 32'h0,          1, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(1, 32'h0,  0, 1, 0, 32'h0,          1, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'h0,  0, 1, 0, 32'h0,          1, 0, 1, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'h4,  0, 1, 1, 32'hA0000001,   1, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'h4,  0, 1, 0, 32'h0,          1, 0, 1, 32'h4,  1, 32'hA0000001,   32'h0, 0));
    tbl.push_back(mkv(0, 32'h8,  0, 1, 1, 32'hA0000002,   1, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'h8,  0, 1, 0, 32'h0,          1, 0, 1, 32'h8,  1, 32'hA0000002,   32'h4, 0));
    tbl.push_back(mkv(0, 32'hC,  0, 1, 1, 32'hA0000003,   1, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'hC,  0, 0, 0, 32'h0,          1, 1, 1, 32'hC,  1, 32'hA0000003,   32'h8, 0));
    // Decode stalled: two entries fill the FIFO, then requests stop until it drains.
    tbl.push_back(mkv(1, 32'h0,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'h0,  0, 1, 0, 32'h0,          0, 0, 1, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'h4,  0, 1, 1, 32'hB0000000,   0, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'h4,  0, 1, 0, 32'h0,          0, 0, 1, 32'h4,  1, 32'hB0000000,   32'h0, 0));
    tbl.push_back(mkv(0, 32'h8,  0, 1, 1, 32'hB0000004,   0, 1, 0, 32'h0,  1, 32'hB0000000,   32'h0, 0));
    tbl.push_back(mkv(0, 32'h8,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,  1, 32'hB0000000,   32'h0, 0));
    tbl.push_back(mkv(0, 32'h8,  0, 1, 0, 32'h0,          0, 1, 0, 32'h0,  1, 32'hB0000000,   32'h0, 0));
    tbl.push_back(mkv(0, 32'h8,  0, 1, 0, 32'h0,          1, 1, 0, 32'h0,  1, 32'hB0000000,   32'h0, 0));
    tbl.push_back(mkv(0, 32'h8,  0, 1, 0, 32'h0,          1, 0, 1, 32'h8,  1, 32'hB0000004,   32'h4, 0));
    tbl.push_back(mkv(0, 32'hC,  0, 1, 1, 32'hB0000008,   1, 1, 0, 32'h0,  0, 32'h0,          32'h0, 0));
    tbl.push_back(mkv(0, 32'hC,  0, 0, 0, 32'h0,          1, 1, 1, 32'hC,  1, 32'hB0000008,   32'h8, 0));

    foreach (tbl[i]) step($sformatf("tbl[%0d]", i), tbl[i]);

    // Redirect while waiting: the late response is dropped and fetch resumes at the new PC.
    step("rdw.rst",   mkv(1, 32'h20,  0, 1, 0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0));
    step("rdw.req",   mkv(0, 32'h20,  0, 1, 0, 32'h0,        1, 0, 1, 32'h20,  0, 32'h0, 32'h0, 0));
    step("rdw.redir", mkv(0, 32'h100, 1, 1, 0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0));
    step("rdw.drop",  mkv(0, 32'h100, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0));
    step("rdw.late",  mkv(0, 32'h100, 0, 1, 1, 32'hDEADBEEF, 1, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0));
    step("rdw.new",   mkv(0, 32'h100, 0, 0, 0, 32'h0,        1, 1, 1, 32'h100, 0, 32'h0, 32'h0, 0));
    step("rdw.empty", mkv(0, 32'h100, 0, 0, 0, 32'h0,        1, 1, 1, 32'h100, 0, 32'h0, 32'h0, 0));

    // Redirect coinciding with rvalid while one entry is buffered.
    step("rdv.rst",   mkv(1, 32'h0,   0, 1, 0, 32'h0,        0, 1, 0, 32'h0,   0, 32'h0,        32'h0, 0));
    step("rdv.req0",  mkv(0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 1, 32'h0,   0, 32'h0,        32'h0, 0));
    step("rdv.rsp0",  mkv(0, 32'h4,   0, 1, 1, 32'hC0000000, 0, 1, 0, 32'h0,   0, 32'h0,        32'h0, 0));
    step("rdv.req1",  mkv(0, 32'h4,   0, 1, 0, 32'h0,        0, 0, 1, 32'h4,   1, 32'hC0000000, 32'h0, 0));
    step("rdv.both",  mkv(0, 32'h200, 1, 1, 1, 32'hC0000004, 0, 1, 0, 32'h0,   0, 32'h0,        32'h0, 0));
    step("rdv.after", mkv(0, 32'h200, 0, 0, 0, 32'h0,        1, 1, 1, 32'h200, 0, 32'h0,        32'h0, 0));

    // Reset in WAIT: the response arriving just after reset must be ignored.
    step("rst.rst",   mkv(1, 32'h40,  0, 1, 0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0));
    step("rst.req",   mkv(0, 32'h40,  0, 1, 0, 32'h0,        1, 0, 1, 32'h40,  0, 32'h0, 32'h0, 0));
    step("rst.mid",   mkv(1, 32'h40,  0, 0, 0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0, 32'h0, 0));
    step("rst.stale", mkv(0, 32'h40,  0, 0, 1, 32'h12345678, 1, 1, 1, 32'h40,  0, 32'h0, 32'h0, 0));
    step("rst.after", mkv(0, 32'h40,  0, 0, 0, 32'h0,        1, 1, 1, 32'h40,  0, 32'h0, 32'h0, 0));

`ifdef FETCH_MISALIGN_CHK_EN
    // Misaligned PC produces a faulting NOP without touching memory.
    step("mis.rst",   mkv(1, 32'h102, 0, 1, 0, 32'h0, 0, 1, 0, 32'h0,   0, 32'h0,        32'h0,   0));
    step("mis.pc",    mkv(0, 32'h102, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0,   0, 32'h0,        32'h0,   0));
    step("mis.head",  mkv(0, 32'h104, 0, 0, 0, 32'h0, 0, 1, 1, 32'h104, 1, 32'h00000013, 32'h102, 1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
